literal_collector: RTL and testbench
====================================

LITERAL_COLLECTOR -- requirements
Module: literal_collector

Interface
REQ-001 SHALL have parameter: MAX_GROUPS, 16, number of 5-bit literal groups held; numberFromBits width = 5*MAX_GROUPS.
REQ-002 SHALL have port: clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port: resetB  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port: start  input  1  one-cycle pulse that begins collection of one literal payload.
REQ-005 SHALL have port: bit_valid  input  1  bit_in carries a valid stream bit.
REQ-006 SHALL have port: bit_in  input  1  serial packet bit, MSB-first.
REQ-007 SHALL have port: bit_ready  output  1  block accepts a bit this cycle.
REQ-008 SHALL have port: numberFromBits  output  5*MAX_GROUPS  collected groups, first group in the top 5 bits.
REQ-009 SHALL have port: enable  output  1  one-cycle pulse; numberFromBits complete and valid.
REQ-010 SHALL have port: busy  output  1  collection in progress.
REQ-011 SHALL have port: group_count  output  5  groups stored for the current payload.
REQ-012 SHALL have port: overflow  output  1  sticky error flag; present only with the macro in REQ-027.

Function
REQ-013 SHALL implement FSM states IDLE, COLLECT, DONE and ERR.
REQ-014 IDLE: start=1 SHALL clear numberFromBits, group_count and the bit counter, then go to COLLECT next cycle.
REQ-015 bit_ready SHALL be 1 only in COLLECT; a bit is accepted iff bit_valid && bit_ready.
REQ-016 Accepted bits SHALL shift into a 5-bit group register; bit_valid low stalls without state change.
REQ-017 On the 5th accepted bit, the group SHALL be written to slot group_count (slot 0 = [5*MAX_GROUPS-1 -: 5]) in the same edge, and group_count SHALL increment.
REQ-018 If the completed group's first bit (continuation) is 0, the FSM SHALL enter DONE; otherwise it SHALL remain in COLLECT.
REQ-019 DONE SHALL last exactly one cycle with enable=1, then return to IDLE; enable latency = 1 cycle after the last bit is accepted.
REQ-020 Unwritten slots SHALL read 0; numberFromBits SHALL hold its value until the next start or reset.
REQ-021 start SHALL be ignored outside IDLE.
REQ-022 busy SHALL be 1 in COLLECT and DONE, and 0 in IDLE and ERR.

Reset
REQ-023 With resetB=0 at a clock edge, the FSM SHALL go to IDLE; numberFromBits=0, enable=0, bit_ready=0, busy=0, group_count=0, overflow=0.
REQ-024 Reset mid-collection SHALL discard the partial payload with no enable pulse.
REQ-025 ERR SHALL be left only by reset.

Configuration
REQ-026 SHALL define macro LITERAL_COLLECTOR_OVERFLOW_CHECK_EN.
REQ-027 With the macro defined: completing a group with continuation=1 when group_count==MAX_GROUPS-1 stores it, then enters ERR; ERR sets overflow=1, bit_ready=0, and never pulses enable.
REQ-028 Without the macro: the overflow port and the ERR state are absent; groups beyond MAX_GROUPS are consumed and discarded, group_count saturates at MAX_GROUPS, and the terminating group still produces enable.

Structure
REQ-029 The shared package SHALL hold GROUP_W=5, the FSM state enum and the default MAX_GROUPS.
REQ-030 The design SHALL be a single module with no sub-modules; output feeds number_top numberFromBits/enable directly.

Verification
REQ-031 Stream 10111 11110 00101 (2021) -> enable once, 1 cycle after the 15th bit; numberFromBits = {10111,11110,00101,65'b0}; group_count=3.
REQ-032 Stream 01010 -> enable after 5 bits; numberFromBits[79:75]=01010, rest 0; group_count=1.
REQ-033 Same stream as REQ-031 with bit_valid low every other cycle -> identical result; enable 1 cycle after the last accepted bit.
REQ-034 resetB=0 after 7 bits, then start and stream 00011 -> no enable before reset; afterwards numberFromBits[79:75]=00011, rest 0.
REQ-035 Macro defined, 16 groups 11111 -> overflow=1 after the 80th bit, bit_ready=0, no enable; macro undefined, 17x11111 then 00000 -> enable, group_count=16.
REQ-036 start pulsed during COLLECT -> ignored; the payload completes unchanged.

Source files
------------

// File: rtl/literal_collector_pkg.sv
// Shared constants and FSM state encoding for the literal collector.
// ERR exists only when LITERAL_COLLECTOR_OVERFLOW_CHECK_EN is defined.
package literal_collector_pkg;

  localparam int GROUP_W            = 5;
  localparam int DEFAULT_MAX_GROUPS = 16;
  localparam int CNT_W              = 5;

`ifdef LITERAL_COLLECTOR_OVERFLOW_CHECK_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2,
    ERR     = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;
`endif

endpackage

// File: rtl/literal_collector.sv
// Collects 5-bit literal groups (continuation bit + 4 data bits) MSB-first into a wide word.
// Define LITERAL_COLLECTOR_OVERFLOW_CHECK_EN to trap payloads longer than MAX_GROUPS in ERR.
module literal_collector
  import literal_collector_pkg::*;
#(
  parameter int MAX_GROUPS = DEFAULT_MAX_GROUPS
) (
  input  logic                          clk,
  input  logic                          resetB,
  input  logic                          start,
  input  logic                          bit_valid,
  input  logic                          bit_in,
  output logic                          bit_ready,
  output logic [GROUP_W*MAX_GROUPS-1:0] numberFromBits,
  output logic                          enable,
  output logic                          busy,
`ifdef LITERAL_COLLECTOR_OVERFLOW_CHECK_EN
  output logic                          overflow,
`endif
  output logic [CNT_W-1:0]              group_count
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_GROUPS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_GROUPS - 1);

  state_t               state;
  logic [GROUP_W-2:0]   shreg;
  logic [2:0]           bit_cnt;
  logic [GROUP_W-1:0]   grp;
  logic                 take;

  // completed group as it will look on the edge that accepts its 5th bit
  assign grp  = {shreg, bit_in};
  assign take = bit_valid && bit_ready;

  always_ff @(posedge clk) begin
    if (!resetB) begin
      state          <= IDLE;
      shreg          <= '0;
      bit_cnt        <= '0;
      numberFromBits <= '0;
      group_count    <= '0;
      enable         <= 1'b0;
      bit_ready      <= 1'b0;
      busy           <= 1'b0;
`ifdef LITERAL_COLLECTOR_OVERFLOW_CHECK_EN
      overflow       <= 1'b0;
`endif
    end else begin
      enable <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            numberFromBits <= '0;
            group_count    <= '0;
            bit_cnt        <= '0;
            shreg          <= '0;
            state          <= COLLECT;
            bit_ready      <= 1'b1;
            busy           <= 1'b1;
          end
        end
        COLLECT: begin
          if (take) begin
            if (bit_cnt == 3'd4) begin
              bit_cnt <= '0;
              if (group_count < MAX_CNT) begin
                for (int s = 0; s < MAX_GROUPS; s++)
                  if (group_count == CNT_W'(s))
                    numberFromBits[GROUP_W*(MAX_GROUPS-1-s) +: GROUP_W] <= grp;
                group_count <= group_count + 1'b1;
              end
              if (!grp[GROUP_W-1]) begin
                state     <= DONE;
                enable    <= 1'b1;
                bit_ready <= 1'b0;
              end
`ifdef LITERAL_COLLECTOR_OVERFLOW_CHECK_EN
              else if (group_count == LAST_CNT) begin
                state     <= ERR;
                overflow  <= 1'b1;
                bit_ready <= 1'b0;
                busy      <= 1'b0;
              end
`endif
            end else begin
              shreg   <= {shreg[GROUP_W-3:0], bit_in};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          // ERR: parked until reset
          bit_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifndef LITERAL_COLLECTOR_OVERFLOW_CHECK_EN
  logic unused_last;
  assign unused_last = ^LAST_CNT;
`endif

endmodule

// File: tb/tb_literal_collector.sv
// Directed bench for literal_collector: expected payloads are queued at stimulus time
// and compared against results captured whenever enable pulses.
module tb_literal_collector;
  import literal_collector_pkg::*;

  localparam int MG = 16;
  localparam int W  = GROUP_W * MG;

  typedef struct packed {
    logic [W-1:0] num;
    logic [4:0]   cnt;
  } res_t;

  logic         clk = 1'b0;
  logic         resetB, start, bit_valid, bit_in;
  logic         bit_ready, enable, busy;
  logic [W-1:0] numberFromBits;
  logic [4:0]   group_count;
`ifdef LITERAL_COLLECTOR_OVERFLOW_CHECK_EN
  logic         overflow;
`endif

  int errors = 0;
  int checks = 0;
  res_t exp_q[$];
  res_t obs_q[$];

  literal_collector #(.MAX_GROUPS(MG)) dut (
    .clk(clk), .resetB(resetB), .start(start), .bit_valid(bit_valid), .bit_in(bit_in),
    .bit_ready(bit_ready), .numberFromBits(numberFromBits), .enable(enable), .busy(busy),
`ifdef LITERAL_COLLECTOR_OVERFLOW_CHECK_EN
    .overflow(overflow),
`endif
    .group_count(group_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (enable) obs_q.push_back('{num: numberFromBits, cnt: group_count});

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    resetB = 1'b0; tick(); tick(); resetB = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input bit gap);
    int n;
    if (gap) begin bit_valid = 1'b0; tick(); end
    bit_valid = 1'b1; bit_in = b; n = 0;
    while (!bit_ready && n < 20) begin tick(); n++; end
    if (n == 20) chk("bit_ready_timeout", 0, 1);
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic send_group(input logic [4:0] g, input bit gap);
    for (int i = 4; i >= 0; i--) send_bit(g[i], gap);
  endtask

  // called right after the terminating bit: enable must already be high
  task automatic expect_result(input string tag);
    res_t e, o;
    chk({tag, "_enable"}, enable, 1);
    chk({tag, "_busy_done"}, busy, 1);
    chk({tag, "_ready_done"}, bit_ready, 0);
    tick();
    chk({tag, "_enable_drop"}, enable, 0);
    chk({tag, "_busy_idle"}, busy, 0);
    chk({tag, "_enable_count"}, obs_q.size(), 1);
    if (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      chk({tag, "_num"}, o.num, e.num);
      chk({tag, "_cnt"}, o.cnt, e.cnt);
      chk({tag, "_hold"}, numberFromBits, e.num);
    end
    obs_q.delete();
  endtask

  initial begin
    logic [W-1:0] v;
    resetB = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    do_reset();
    chk("rst_num", numberFromBits, 0);
    chk("rst_enable", enable, 0);
    chk("rst_ready", bit_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", group_count, 0);
`ifdef LITERAL_COLLECTOR_OVERFLOW_CHECK_EN
    chk("rst_overflow", overflow, 0);
`endif

    // 2021 = 10111 11110 00101
    v = '0; v[79:65] = 15'b10111_11110_00101;
    exp_q.push_back('{num: v, cnt: 5'd3});
    do_start();
    chk("start_busy", busy, 1);
    chk("start_ready", bit_ready, 1);
    chk("start_cleared_cnt", group_count, 0);
    send_group(5'b10111, 0); send_group(5'b11110, 0); send_group(5'b00101, 0);
    expect_result("p2021");

    // single terminating group
    v = '0; v[79:75] = 5'b01010;
    exp_q.push_back('{num: v, cnt: 5'd1});
    do_start();
    chk("p0a_cleared_num", numberFromBits, 0);
    send_group(5'b01010, 0);
    expect_result("p0a");

    // 2021 with bit_valid low every other cycle
    v = '0; v[79:65] = 15'b10111_11110_00101;
    exp_q.push_back('{num: v, cnt: 5'd3});
    do_start();
    send_group(5'b10111, 1);
    bit_valid = 1'b0; tick(); tick();
    chk("stall_cnt", group_count, 1);
    chk("stall_ready", bit_ready, 1);
    send_group(5'b11110, 1); send_group(5'b00101, 1);
    expect_result("p2021_gap");

    // reset mid-payload, then a fresh payload
    do_start();
    send_group(5'b10111, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
    do_reset();
    tick(); tick();
    chk("midrst_no_enable", obs_q.size(), 0);
    chk("midrst_num", numberFromBits, 0);
    chk("midrst_cnt", group_count, 0);
    chk("midrst_busy", busy, 0);
    v = '0; v[79:75] = 5'b00011;
    exp_q.push_back('{num: v, cnt: 5'd1});
    do_start();
    send_group(5'b00011, 0);
    expect_result("post_rst");

    // start during COLLECT is ignored
    v = '0; v[79:70] = 10'b11110_00001;
    exp_q.push_back('{num: v, cnt: 5'd2});
    do_start();
    send_group(5'b11110, 0);
    do_start();
    chk("ign_start_cnt", group_count, 1);
    chk("ign_start_num", numberFromBits[79:75], 5'b11110);
    send_group(5'b00001, 0);
    expect_result("ign_start");

`ifdef LITERAL_COLLECTOR_OVERFLOW_CHECK_EN
    do_start();
    for (int g = 0; g < MG; g++) send_group(5'b11111, 0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_ready", bit_ready, 0);
    chk("ovf_busy", busy, 0);
    chk("ovf_enable", enable, 0);
    chk("ovf_cnt", group_count, 16);
    chk("ovf_num", numberFromBits, {W{1'b1}});
    do_start();
    tick(); tick(); tick();
    chk("ovf_sticky", overflow, 1);
    chk("ovf_no_enable", obs_q.size(), 0);
    do_reset();
    chk("ovf_rst_clear", overflow, 0);
`else
    exp_q.push_back('{num: {W{1'b1}}, cnt: 5'd16});
    do_start();
    for (int g = 0; g < MG + 1; g++) send_group(5'b11111, 0);
    chk("sat_cnt", group_count, 16);
    chk("sat_no_enable_yet", obs_q.size(), 0);
    send_group(5'b00000, 0);
    expect_result("sat");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
